wbuf_tracker: RTL and testbench
===============================

// Module: wbuf_tracker
// PURPOSE
//  AW/W tracker that sits directly upstream of the per-WID write-data fifo array.
//  - Allocates one fifo slot per accepted AW and tags the slot with AWID.
//  - Steers W beats (AXI3-style, with WID) to the slot whose tag matches WID.
//  - Counts the beats accepted by each slot.
//  - When the beat count reaches AWLEN+1, flushes the slot, waits for flush_done, then frees it.
// PARAMETERS
//  NUM_SLOT  4   number of downstream fifos (one tracked burst each)
//  ID_W      11  AWID/WID width; matches the fifo wid/tag width
//  LEN_W     8   AWLEN width; burst = AWLEN+1 beats
// PORTS
//  clk            in   1             clock
//  rst            in   1             async active-high reset
//  aw_valid       in   1             AW request
//  aw_ready       out  1             AW accepted when aw_valid&aw_ready
//  aw_id          in   ID_W          AWID
//  aw_len         in   LEN_W         AWLEN
//  w_valid        in   1             W beat present (data goes straight to fifo_in)
//  w_ready        out  1             W beat accepted
//  w_id           in   ID_W          WID
//  w_last         in   1             WLAST
//  fifo_valid     out  NUM_SLOT      per-slot valid_in to fifo
//  fifo_ready     in   NUM_SLOT      per-slot ready_out from fifo
//  fifo_wid       out  NUM_SLOT*ID_W per-slot wid tag; slot i at [i*ID_W +: ID_W]
//  fifo_flush     out  NUM_SLOT      per-slot flush request
//  fifo_flush_done in  NUM_SLOT      per-slot flush completion
// BEHAVIOUR
//  - Reset (async, rst=1): all slots IDLE, all counts 0, tags 0.
//    Outputs at reset: aw_ready=0, w_ready=0, fifo_valid=0, fifo_flush=0, fifo_wid=0.
//  - Per-slot FSM:
//    - IDLE -> ACTIVE on AW handshake allocated to the slot. Tag<=aw_id, len<=aw_len, cnt<=0.
//    - ACTIVE -> FLUSH on the clock edge that accepts beat number len+1.
//    - FLUSH -> IDLE on fifo_flush_done=1. cnt is cleared on this transition.
//  - Allocation:
//    - aw_ready = (any IDLE slot) & (no ACTIVE/FLUSH slot has tag==aw_id). Same ID never occupies two slots.
//    - The lowest-index IDLE slot is chosen.
//    - aw_ready is computed from registered state only.
//  - Steering (combinational, zero latency):
//    - match[i] = ACTIVE[i] & (tag[i]==w_id).
//    - fifo_valid[i] = w_valid & match[i].
//    - w_ready = |(match & fifo_ready).
//    - No matching slot -> w_ready=0; the beat stalls until its AW has been allocated.
//  - Counting:
//    - cnt is LEN_W+1 bits; incremented on fifo_valid[i] & fifo_ready[i].
//    - Maximum burst AWLEN=2^LEN_W-1 must not wrap cnt.
//  - Flush:
//    - fifo_flush[i] = 1 in every FLUSH cycle, starting the cycle after the last beat is accepted.
//    - Held until fifo_flush_done[i]; deasserts the cycle after.
//    - fifo_flush_done[i] in a non-FLUSH state is ignored.
//  - fifo_wid[i] holds the tag while ACTIVE/FLUSH and 0 when IDLE.
//  - Simultaneous events:
//    - AW and W with the same ID in the same cycle: W is not accepted; slot becomes ACTIVE next edge.
//    - flush_done freeing a slot while aw_valid is high: the slot is allocatable the following cycle.
//    - Different slots may flush and accept beats in the same cycle.
//  - AW with the same ID as a flushing slot stalls until that slot returns to IDLE.
//  - rst asserted mid-burst: all state is discarded immediately; partial bursts are not flushed.
// CONFIGURATION
//  - Macro WBUF_TRACKER_WLAST_CHECK_EN defined:
//    - Adds output err_wlast (1b).
//    - err_wlast is a sticky flag, set when an accepted beat has w_last != (cnt==len). Cleared only by rst.
//    - Beat counting is unchanged.
//  - Macro not defined: port absent; w_last is ignored.
// TESTING
//  1. Single burst: AW id=0x05 len=3, 4 W beats id=0x05, fifo_ready=1
//     -> slot0 fifo_valid on 4 beats; fifo_flush[0]=1 the cycle after beat 4.
//     -> flush_done -> slot0 IDLE; fifo_wid[0]=0 next cycle.
//  2. Full/duplicate: 4 AWs ids 1..4 -> aw_ready=0 with all 4 slots ACTIVE.
//     -> AW id=2 also stalls after one slot frees, until slot with tag 2 is IDLE.
//  3. Interleave: AW id=1 len=1, AW id=2 len=1; W beats 2,1,2,1
//     -> slot1 and slot0 each count 2; both flush; beats land in correct fifos.
//  4. Early W/backpressure: W id=7 before its AW -> w_ready=0 until the cycle after AW id=7 is accepted.
//     -> fifo_ready[i]=0 holds w_ready=0 and cnt unchanged.
//  5. Reset mid-burst: AW len=7, 3 beats, rst pulse
//     -> all outputs 0, slots IDLE; new AW accepted normally after rst release.
//  6. (WLAST_CHECK_EN) len=1 with w_last on beat 1 -> err_wlast=1 and stays 1; flush still on beat 2.

Source files
------------

// File: rtl/wbuf_tracker.sv
// wbuf_tracker
//   Tracks AW/W traffic in front of a per-WID write-data fifo array. Each
//   accepted AW claims one idle slot, and that slot is tagged with AWID. W beats
//   carry a WID and are steered to the slot whose tag matches. Each slot counts
//   the beats it accepts. After AWLEN+1 beats the slot asks its fifo to flush.
//   It waits for flush_done and then returns to idle.
//
// Ports
//   clk, rst         clock and asynchronous active-high reset
//   aw_valid/ready   AW handshake; aw_id / aw_len give the tag and burst length
//   w_valid/ready    W handshake; w_id selects the slot; w_last is WLAST
//   fifo_valid[i]    valid_in to fifo i (W beat steered to slot i)
//   fifo_ready[i]    ready_out from fifo i
//   fifo_wid         slot tags, slot i at [i*ID_W +: ID_W]; 0 while idle
//   fifo_flush[i]    flush request, held while slot i is flushing
//   fifo_flush_done  per-slot flush completion
//   err_wlast        sticky WLAST mismatch flag. It exists only when the
//                    WBUF_TRACKER_WLAST_CHECK_EN macro is defined.
//
// Configuration
//   WBUF_TRACKER_WLAST_CHECK_EN: when defined, adds err_wlast. When undefined,
//   w_last is ignored.

module wbuf_tracker #(
    parameter int NUM_SLOT = 4,
    parameter int ID_W     = 11,
    parameter int LEN_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [ID_W-1:0]          aw_id,
    input  logic [LEN_W-1:0]         aw_len,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [ID_W-1:0]          w_id,
    input  logic                     w_last,
    output logic [NUM_SLOT-1:0]      fifo_valid,
    input  logic [NUM_SLOT-1:0]      fifo_ready,
    output logic [NUM_SLOT*ID_W-1:0] fifo_wid,
    output logic [NUM_SLOT-1:0]      fifo_flush,
`ifdef WBUF_TRACKER_WLAST_CHECK_EN
    output logic                     err_wlast,
`endif
    input  logic [NUM_SLOT-1:0]      fifo_flush_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } slot_state_t;

    logic [NUM_SLOT-1:0] idle;        // slot free
    logic [NUM_SLOT-1:0] dup;         // occupied slot already holds aw_id
    logic [NUM_SLOT-1:0] match;       // active slot tagged with w_id
    logic [NUM_SLOT-1:0] accept;      // beat accepted by slot this cycle
    logic [NUM_SLOT-1:0] last_beat;   // the beat now accepted would be the final one
    logic [NUM_SLOT-1:0] alloc;       // one-hot lowest idle slot
    logic                aw_fire;

    // Only registered slot state feeds aw_ready. A slot freed by flush_done
    // this cycle therefore becomes allocatable the cycle after. During reset
    // aw_ready is forced low because every slot already looks idle.
    assign aw_ready = !rst && (|idle) && !(|dup);
    assign aw_fire  = aw_valid && aw_ready;
    assign alloc    = idle & (~idle + NUM_SLOT'(1));

    // A given ID is never held by two slots, so at most one slot matches.
    assign w_ready  = |(match & fifo_ready);

    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
        slot_state_t        state_reg;
        slot_state_t        state_next;
        logic [ID_W-1:0]    tag_reg;
        logic [LEN_W-1:0]   len_reg;
        // This counter is one bit wider than len, so the maximum burst of
        // 2^LEN_W beats fits without wrapping.
        logic [LEN_W:0]     cnt_reg;
        logic               valid_o;
        logic               flush_o;
        logic [ID_W-1:0]    wid_o;

        assign idle[gi]      = (state_reg == S_IDLE);
        assign dup[gi]       = (state_reg != S_IDLE) && (tag_reg == aw_id);
        assign match[gi]     = (state_reg == S_ACTIVE) && (tag_reg == w_id);
        assign accept[gi]    = w_valid && match[gi] && fifo_ready[gi];
        assign last_beat[gi] = (cnt_reg == {1'b0, len_reg});

        // State register and slot datapath
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg <= S_IDLE;
                tag_reg   <= '0;
                len_reg   <= '0;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                if (state_reg == S_IDLE && aw_fire && alloc[gi]) begin
                    tag_reg <= aw_id;
                    len_reg <= aw_len;
                    cnt_reg <= '0;
                end else if (accept[gi]) begin
                    cnt_reg <= cnt_reg + (LEN_W+1)'(1);
                end else if (state_reg == S_FLUSH && fifo_flush_done[gi]) begin
                    cnt_reg <= '0;
                end
            end
        end

        // Next-state logic
        always_comb begin
            state_next = state_reg;
            case (state_reg)
                S_IDLE:   if (aw_fire && alloc[gi])           state_next = S_ACTIVE;
                S_ACTIVE: if (accept[gi] && last_beat[gi])    state_next = S_FLUSH;
                S_FLUSH:  if (fifo_flush_done[gi])            state_next = S_IDLE;
                default:                                      state_next = S_IDLE;
            endcase
        end

        // Output logic
        always_comb begin
            valid_o = 1'b0;
            flush_o = 1'b0;
            wid_o   = '0;
            if (state_reg != S_IDLE) wid_o = tag_reg;
            if (state_reg == S_FLUSH) flush_o = 1'b1;
            if (w_valid && match[gi]) valid_o = 1'b1;
        end

        assign fifo_valid[gi]               = valid_o;
        assign fifo_flush[gi]               = flush_o;
        assign fifo_wid[gi*ID_W +: ID_W]    = wid_o;
    end

`ifdef WBUF_TRACKER_WLAST_CHECK_EN
    logic [NUM_SLOT-1:0] wlast_bad;

    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_wlast
        assign wlast_bad[gi] = accept[gi] && (w_last != last_beat[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_wlast <= 1'b0;
        else if (|wlast_bad)
            err_wlast <= 1'b1;
    end
`else
    logic unused_w_last;
    assign unused_w_last = w_last;
`endif

endmodule

// File: tb/tb_wbuf_tracker.sv
// Randomized scoreboard bench for wbuf_tracker. A slot-level reference model
// tracks occupancy, tag, beats remaining and flush state. Each cycle it
// predicts the full output vector and any accepted beat. A monitor compares
// those predictions with the DUT on the falling edge.
module tb_wbuf_tracker;
    localparam int NS = 4;
    localparam int IW = 11;
    localparam int LW = 8;
    localparam int NCYC = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              aw_valid;
    logic              aw_ready;
    logic [IW-1:0]     aw_id;
    logic [LW-1:0]     aw_len;
    logic              w_valid;
    logic              w_ready;
    logic [IW-1:0]     w_id;
    logic              w_last;
    logic [NS-1:0]     fifo_valid;
    logic [NS-1:0]     fifo_ready;
    logic [NS*IW-1:0]  fifo_wid;
    logic [NS-1:0]     fifo_flush;
    logic [NS-1:0]     fifo_flush_done;
`ifdef WBUF_TRACKER_WLAST_CHECK_EN
    logic              err_wlast;
`endif

    always #5 clk = ~clk;

    wbuf_tracker #(.NUM_SLOT(NS), .ID_W(IW), .LEN_W(LW)) dut (
        .clk             (clk),
        .rst             (rst),
        .aw_valid        (aw_valid),
        .aw_ready        (aw_ready),
        .aw_id           (aw_id),
        .aw_len          (aw_len),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_id            (w_id),
        .w_last          (w_last),
        .fifo_valid      (fifo_valid),
        .fifo_ready      (fifo_ready),
        .fifo_wid        (fifo_wid),
        .fifo_flush      (fifo_flush),
`ifdef WBUF_TRACKER_WLAST_CHECK_EN
        .err_wlast       (err_wlast),
`endif
        .fifo_flush_done (fifo_flush_done)
    );

    typedef struct packed {
        logic             aw_ready;
        logic             w_ready;
        logic [NS-1:0]    fvalid;
        logic [NS-1:0]    fflush;
        logic [NS*IW-1:0] fwid;
        logic             err;
    } obs_t;

    obs_t exp_q[$];
    int   beat_q[$];
    int   checks = 0;
    int   failures = 0;
    int   max_bursts = 0;

    // Reference model: one record per downstream fifo
    bit          m_busy[NS];
    bit          m_flush[NS];
    logic [IW-1:0] m_id[NS];
    int          m_left[NS];
    bit          m_err;

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            m_busy[i] = 0; m_flush[i] = 0; m_id[i] = '0; m_left[i] = 0;
        end
        m_err = 0;
    endfunction

    function automatic bit model_aw_ok();
        bit any_free = 0;
        bit taken = 0;
        for (int i = 0; i < NS; i++) begin
            if (!m_busy[i]) any_free = 1;
            else if (m_id[i] == aw_id) taken = 1;
        end
        return any_free && !taken;
    endfunction

    // Slot that will take the current W beat, or -1
    function automatic int model_beat_slot();
        for (int i = 0; i < NS; i++)
            if (m_busy[i] && !m_flush[i] && m_id[i] == w_id && w_valid && fifo_ready[i])
                return i;
        return -1;
    endfunction

    function automatic obs_t predict();
        obs_t o;
        o = '0;
        if (rst) return o;
        o.aw_ready = model_aw_ok();
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i]) o.fwid[i*IW +: IW] = m_id[i];
            if (m_busy[i] && m_flush[i]) o.fflush[i] = 1'b1;
            if (m_busy[i] && !m_flush[i] && m_id[i] == w_id) begin
                if (w_valid) o.fvalid[i] = 1'b1;
                if (fifo_ready[i]) o.w_ready = 1'b1;
            end
        end
`ifdef WBUF_TRACKER_WLAST_CHECK_EN
        o.err = m_err;
`endif
        return o;
    endfunction

    // Advance the model across one rising edge, using the inputs still applied
    function automatic void model_step();
        int acc;
        int fre;
        bit aw_ok;
        if (rst) begin
            model_clear();
            return;
        end
        aw_ok = model_aw_ok();
        acc = model_beat_slot();
        fre = -1;
        for (int i = NS-1; i >= 0; i--) if (!m_busy[i]) fre = i;
        for (int i = 0; i < NS; i++)
            if (m_busy[i] && m_flush[i] && fifo_flush_done[i]) begin
                m_busy[i] = 0; m_flush[i] = 0;
            end
        if (acc >= 0) begin
            if (w_last != (m_left[acc] == 1)) m_err = 1;
            m_left[acc] = m_left[acc] - 1;
            if (m_left[acc] == 0) m_flush[acc] = 1;
        end
        if (aw_valid && aw_ok) begin
            m_busy[fre] = 1; m_flush[fre] = 0;
            m_id[fre] = aw_id;
            m_left[fre] = int'(aw_len) + 1;
            if (aw_len == '1) max_bursts++;
        end
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.aw_ready = aw_ready;
        s.w_ready  = w_ready;
        s.fvalid   = fifo_valid;
        s.fflush   = fifo_flush;
        s.fwid     = fifo_wid;
`ifdef WBUF_TRACKER_WLAST_CHECK_EN
        s.err      = err_wlast;
`else
        s.err      = 1'b0;
`endif
        return s;
    endfunction

    // Monitor: compares DUT outputs with queued predictions
    initial begin
        obs_t e;
        obs_t a;
        int   want;
        int   got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    failures++;
                    if (failures <= 30)
                        $display("FAIL outputs t=%0t got=%h want=%h", $time, a, e);
                end
            end
            if (w_valid && w_ready) begin
                got = -1;
                for (int i = NS-1; i >= 0; i--) if (fifo_valid[i] && fifo_ready[i]) got = i;
                checks++;
                if (beat_q.size() == 0) begin
                    failures++;
                    if (failures <= 30)
                        $display("FAIL beat_unexpected t=%0t got_slot=%0d want=none", $time, got);
                end else begin
                    want = beat_q.pop_front();
                    if (got != want) begin
                        failures++;
                        if (failures <= 30)
                            $display("FAIL beat_slot t=%0t got_slot=%0d want_slot=%0d", $time, got, want);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        obs_t o;
        int   s;
        int   cand[$];
        bit   pulse;
        model_clear();
        rst = 1'b1; aw_valid = 0; aw_id = '0; aw_len = '0;
        w_valid = 0; w_id = '0; w_last = 0; fifo_ready = '0; fifo_flush_done = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            pulse = (cyc > 100) && ($urandom_range(0, 1999) == 0);
            rst = (cyc < 3) || pulse;
            aw_valid = ($urandom_range(0, 2) != 0);
            aw_id = IW'($urandom_range(1, 6));
            aw_len = ($urandom_range(0, 59) == 0) ? '1 : LW'($urandom_range(0, 3));
            w_valid = ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int i = 0; i < NS; i++) if (m_busy[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8) begin
                s = cand[$urandom_range(0, cand.size()-1)];
                w_id = m_id[s];
                w_last = (m_left[s] == 1);
            end else begin
                w_id = IW'($urandom_range(1, 7));
                w_last = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 9) == 0) w_last = !w_last;
            fifo_ready = NS'($urandom_range(0, 15));
            fifo_flush_done = NS'($urandom_range(0, 15) & $urandom_range(0, 15));
            o = predict();
            exp_q.push_back(o);
            if (!rst) begin
                s = model_beat_slot();
                if (s >= 0) beat_q.push_back(s);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || beat_q.size() != 0) begin
            failures++;
            $display("FAIL drain got_exp=%0d got_beats=%0d want=0", exp_q.size(), beat_q.size());
        end
        checks++;
        if (max_bursts == 0) begin
            failures++;
            $display("FAIL max_len_coverage got=%0d want>0", max_bursts);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
